// File: rtl/alu_arbiter.sv
// Two requesters share one 32-bit ALU; at most one operation is in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: requester 0 has priority).

module alu_32bit_unsigned (
  input  logic [2:0]  i_opcode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_result,
  output logic        o_cout
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  // Keep the low b bits of a; a count of DATA_W or more keeps every bit.
  function automatic logic [DATA_W-1:0] cut_bits(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] mask;
    if (b >= 32'(DATA_W)) mask = '1;
    else                  mask = ~({DATA_W{1'b1}} << b[CNT_W-1:0]);
    return a & mask;
  endfunction

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};

  always_comb begin
    o_result = '0;
    o_cout   = 1'b0;
    case (i_opcode)
      3'd0: o_result = ~i_a;
      3'd1: o_result = i_a & i_b;
      3'd2: o_result = i_a | i_b;
      3'd3: o_result = i_a ^ i_b;
      3'd4: o_result = i_a << i_b;
      3'd5: o_result = i_a >> i_b;
      3'd6: o_result = cut_bits(i_a, i_b);
      3'd7: begin
        o_result = w_sum[DATA_W-1:0];
        o_cout   = w_sum[DATA_W];
      end
      default: ;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        busy
);

  localparam logic [1:0] CNT_LAST = 2'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_cnt;
  logic [2:0]  r_opcode;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_cin;
  logic        r_owner;
  logic [31:0] r_result;
  logic        r_cout;

  logic        w_grant1;
  logic        w_accept;
  logic        w_exec_done;
  logic        w_rsp_done;
  logic [2:0]  w_sel_opcode;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic        w_sel_cin;
  logic [31:0] w_alu_result;
  logic        w_alu_cout;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // r_last holds the id of the most recent winner; the other requester wins a tie.
  logic r_last;

  always_comb begin
    if (req0_valid && req1_valid) w_grant1 = ~r_last;
    else                          w_grant1 = req1_valid & ~req0_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_last <= 1'b1;
    else if (w_accept) r_last <= w_grant1;
  end
`else
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign w_accept    = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == CNT_LAST);
  assign w_rsp_done  = (r_state == S_RESP) &&
                       ((!r_owner && rsp0_ready) || (r_owner && rsp1_ready));

  assign w_sel_opcode = w_grant1 ? req1_opcode : req0_opcode;
  assign w_sel_a      = w_grant1 ? req1_a      : req0_a;
  assign w_sel_b      = w_grant1 ? req1_b      : req0_b;
  assign w_sel_cin    = w_grant1 ? req1_cin    : req0_cin;

  alu_32bit_unsigned u_alu (
    .i_opcode (r_opcode),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_cin    (r_cin),
    .o_result (w_alu_result),
    .o_cout   (w_alu_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_next = S_RESP;
      S_RESP:  if (w_rsp_done)  w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Operands are captured on accept so later req-side changes cannot disturb the op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_opcode <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_owner  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_opcode <= w_sel_opcode;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_cin    <= w_sel_cin;
        r_owner  <= w_grant1;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_exec_done) begin
        r_result <= w_alu_result;
        r_cout   <= w_alu_cout;
      end
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid & ~w_grant1;
        req1_ready = req1_valid &  w_grant1;
      end
      S_RESP: begin
        rsp0_valid = ~r_owner;
        rsp1_valid =  r_owner;
      end
      default: ;
    endcase
  end

  assign rsp_result = r_result;
  assign rsp_cout   = r_cout;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: default instance plus an EXEC_CYCLES=3 instance.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout, busy;

  logic        t3_req0_valid, t3_req1_valid, t3_req0_ready, t3_req1_ready;
  logic [2:0]  t3_req0_opcode, t3_req1_opcode;
  logic [31:0] t3_req0_a, t3_req0_b, t3_req1_a, t3_req1_b;
  logic        t3_req0_cin, t3_req1_cin;
  logic        t3_rsp0_valid, t3_rsp1_valid, t3_rsp0_ready, t3_rsp1_ready;
  logic [31:0] t3_rsp_result;
  logic        t3_rsp_cout, t3_busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy)
  );

  alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_opcode(t3_req0_opcode),
    .req0_a(t3_req0_a), .req0_b(t3_req0_b), .req0_cin(t3_req0_cin),
    .req1_valid(t3_req1_valid), .req1_ready(t3_req1_ready), .req1_opcode(t3_req1_opcode),
    .req1_a(t3_req1_a), .req1_b(t3_req1_b), .req1_cin(t3_req1_cin),
    .rsp0_valid(t3_rsp0_valid), .rsp0_ready(t3_rsp0_ready),
    .rsp1_valid(t3_rsp1_valid), .rsp1_ready(t3_rsp1_ready),
    .rsp_result(t3_rsp_result), .rsp_cout(t3_rsp_cout), .busy(t3_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cin);
    if (id == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  // Issue one op, check latency (2 cycles), result, cout, channel exclusivity and return to idle.
  task automatic run_op(input string tag, input int id, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] exp_res, input logic exp_cout);
    int  lat;
    bit  got;
    @(posedge clk); #1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(id, 1'b1, op, a, b, cin);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin got = 1; break; end
    end
    check({tag, "_acc"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    set_req(id, 1'b0, ~op, ~a, ~b, ~cin);
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((id == 0) ? rsp0_valid : rsp1_valid) break;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_res"}, rsp_result, exp_res);
    check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
    check({tag, "_other"}, 32'((id == 0) ? rsp1_valid : rsp0_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle"}, 32'({busy, rsp0_valid, rsp1_valid}), 32'd0);
  endtask

  initial begin
    int      lat, nv, n, n0, n1;
    bit      got;
    int      order [8];
    int      exp_id;

    rst_n = 1'b0;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    t3_req0_valid = 1'b0; t3_req0_opcode = 3'd0; t3_req0_a = '0; t3_req0_b = '0; t3_req0_cin = 1'b0;
    t3_req1_valid = 1'b0; t3_req1_opcode = 3'd0; t3_req1_a = '0; t3_req1_b = '0; t3_req1_cin = 1'b0;
    t3_rsp0_ready = 1'b0; t3_rsp1_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rspv", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_cout", 32'(rsp_cout), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add_ovf", 0, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    run_op("shl",     1, 3'd4, 32'h0000_0001, 32'h0000_0004, 1'b0, 32'h0000_0010, 1'b0);
    run_op("not",     0, 3'd0, 32'h0F0F_0000, 32'h1234_5678, 1'b1, 32'hF0F0_FFFF, 1'b0);
    run_op("and",     1, 3'd1, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h0F00_0F00, 1'b0);
    run_op("or",      0, 3'd2, 32'hF000_0001, 32'h0000_1000, 1'b0, 32'hF000_1001, 1'b0);
    run_op("shr",     1, 3'd5, 32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001, 1'b0);
    run_op("cut0",    0, 3'd6, 32'hFFFF_FFFF, 32'd0,         1'b0, 32'h0000_0000, 1'b0);
    run_op("addcin",  1, 3'd7, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0);
    run_op("xorcin",  0, 3'd3, 32'h0000_00F0, 32'h0000_00FF, 1'b1, 32'h0000_000F, 1'b0);

    // Response held back: outputs must stay stable, readies low, busy high.
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    set_req(0, 1'b1, 3'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1; break; end
    end
    check("hold_acc", 32'(got), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp0_valid) break;
    end
    set_req(0, 1'b1, 3'd7, 32'd1, 32'd1, 1'b0);
    set_req(1, 1'b1, 3'd7, 32'd2, 32'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      check("hold_valid", 32'({rsp0_valid, rsp1_valid}), 32'b10);
      check("hold_res", rsp_result, 32'h5A5A_5A5A);
      check("hold_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_done", 32'({busy, rsp0_valid}), 32'd0);

    // Reset during EXEC discards the operation.
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd7, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    check("rstx_acc", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstx_busy", 32'(busy), 32'd0);
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) nv++;
    end
    check("rstx_norsp", 32'(nv), 32'd0);
    run_op("rstx_next", 0, 3'd7, 32'd5, 32'd6, 1'b0, 32'd11, 1'b0);

    // Arbitration order with both requesters valid; reset first so the pointer is fresh.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 1'b1, 3'd7, 32'd1, 32'd1, 1'b0);
    set_req(1, 1'b1, 3'd3, 32'd3, 32'd1, 1'b0);
    for (int i = 0; i < 8; i++) order[i] = -1;
    n = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (req0_ready) begin order[n] = 0; n++; n0++; end
      else if (req1_ready) begin order[n] = 1; n++; n1++; end
      @(posedge clk); #1;
      if (n0 == 4) req0_valid = 1'b0;
      if (n1 == 4) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = i % 2;
`else
      exp_id = (i < 4) ? 0 : 1;
`endif
      check("arb_order", 32'(order[i]), 32'(exp_id));
    end
    repeat (6) @(posedge clk);

    // EXEC_CYCLES=3 instance: CUT with a count of 8.
    #1;
    t3_rsp0_ready = 1'b1;
    t3_req0_valid = 1'b1; t3_req0_opcode = 3'd6; t3_req0_a = 32'hFFFF_FFFF; t3_req0_b = 32'd8;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (t3_req0_ready) begin got = 1; break; end
    end
    check("t3_acc", 32'(got), 32'd1);
    check("t3_rdy1", 32'(t3_req1_ready), 32'd0);
    @(posedge clk); #1;
    t3_req0_valid = 1'b0; t3_req0_a = 32'd0; t3_req0_b = 32'd0;
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (t3_rsp0_valid) break;
      lat++;
    end
    check("t3_lat", 32'(lat), 32'd4);
    check("t3_res", t3_rsp_result, 32'h0000_00FF);
    check("t3_cout", 32'(t3_rsp_cout), 32'd0);
    check("t3_other", 32'(t3_rsp1_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_idle", 32'({t3_busy, t3_rsp0_valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, number of cycles the ALU operands are held before the result is captured (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester i presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester i's operation is accepted this cycle.
REQ-006 SHALL have ports req0_opcode/req1_opcode  input  3  ALU opcode: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 SHR, 6 CUT, 7 ADD.
REQ-007 SHALL have ports req0_a/req1_a and req0_b/req1_b  input  32  operands; shift/cut count is taken from b.
REQ-008 SHALL have ports req0_cin/req1_cin  input  1  carry in, used only by ADD.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid  output  1  result for requester i is available.
REQ-010 SHALL have ports rsp0_ready/rsp1_ready  input  1  requester i consumes its result.
REQ-011 SHALL have ports rsp_result  output  32 and rsp_cout  output  1, shared by both response channels, valid only while some rspi_valid=1.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL instantiate exactly one alu_32bit_unsigned, driven only from internally latched opcode/a/b/cin registers.
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; at most one operation in flight.
REQ-015 In IDLE, SHALL assert reqi_ready combinationally for exactly the granted requester, and only when reqi_valid=1; the other ready SHALL be 0; in EXEC and RESP both readies SHALL be 0.
REQ-016 On accept (reqi_valid and reqi_ready), SHALL latch opcode, a, b, cin and the owner id, then enter EXEC with exec counter = 0.
REQ-017 In EXEC, SHALL increment the counter each cycle; when it equals EXEC_CYCLES-1, SHALL register the ALU result and cout and enter RESP.
REQ-018 rspi_valid SHALL rise exactly EXEC_CYCLES+1 cycles after the accept cycle (default: 2) on the owner's channel only.
REQ-019 In RESP, SHALL hold rspi_valid, rsp_result and rsp_cout stable until rspi_ready=1; on that cycle SHALL return to IDLE, with rspi_valid low the next cycle.
REQ-020 SHALL not accept a new request in the cycle the response completes; the earliest next accept is the following cycle (back-to-back throughput: one operation per EXEC_CYCLES+2 cycles).
REQ-021 rsp_cout SHALL be 0 for every opcode other than 7, as returned by the ALU.
REQ-022 Changes on req inputs after accept SHALL have no effect on the in-flight result.
REQ-023 rspi_ready asserted while rspi_valid=0 SHALL be ignored.

Reset
REQ-024 On rst_n=0 at a rising edge, SHALL force state IDLE, counter 0, latched operands 0, rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_cout=0, busy=0, last-grant pointer=1.
REQ-025 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is ever issued for it.

Configuration
REQ-026 With macro ALU_ARB_ROUND_ROBIN_EN defined, when both reqs are valid in IDLE the requester not recorded in the last-grant pointer SHALL win, and the pointer SHALL update to the winner on each accept; a single valid requester always wins.
REQ-027 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win when both are valid, and the pointer SHALL be absent or unused.

Verification
REQ-028 Req0 ADD a=0xFFFFFFFF b=0x00000001 cin=0, rsp0_ready=1 -> rsp0_valid at accept+2, rsp_result=0x00000000, rsp_cout=1; rsp1_valid stays 0.
REQ-029 Req1 SHL a=0x00000001 b=0x00000004 -> rsp1_valid at accept+2, rsp_result=0x00000010, rsp_cout=0.
REQ-030 Both valid continuously, four ops each, rsp ready always 1, RR enabled -> accept order 0,1,0,1,...; without macro -> four req0 accepts before any req1 accept.
REQ-031 Req0 XOR a=0xA5A5A5A5 b=0xFFFFFFFF, rsp0_ready held 0 for 5 cycles -> rsp0_valid=1 and rsp_result=0x5A5A5A5A stable all 5 cycles, req0_ready=req1_ready=0 throughout, busy=1.
REQ-032 rst_n pulsed low one cycle after accept of ADD -> no rsp valid follows, busy=0 after reset edge, next request accepted normally.
REQ-033 EXEC_CYCLES=3, req0 CUT a=0xFFFFFFFF b=8 -> rsp0_valid at accept+4, rsp_result=0x000000FF.
